// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans a 4x4 active-low matrix keypad, synchronises and debounces
//            the rows, and reports one key code per accepted press.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SCAN_DIV        CLK cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive full scans to accept a press / a release (2..15)
// Ports
//   CLK        in   system (divided) clock
//   RST        in   asynchronous active-low reset
//   row_in     in   [3:0] keypad rows, active-low, asynchronous to CLK
//   col_drive  out  [3:0] column select, active-low one-hot
//   key_code   out  [3:0] last accepted key, row*4+col
//   key_valid  out  one-cycle pulse per accepted press
//   key_held   out  high while the accepted key stays pressed
//   entry_req  out  entry request pulse (keymap build only)
//   exit_req   out  exit request pulse (keymap build only)
//   exit_slot  out  [1:0] slot latched for exit (keymap build only)
// Build option
//   PARK_KEYMAP_EN  when defined, maps accepted codes onto parking requests;
//                   otherwise entry_req/exit_req/exit_slot are tied to 0.
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       entry_req,
  output logic       exit_req,
  output logic [1:0] exit_slot
);

  localparam int               c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       c_DEB      = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  // Scan timing and synchroniser
  logic [c_DIV_W-1:0] r_div;
  logic [1:0]         r_col_idx;
  logic [3:0]         r_col_drive;
  logic [3:0]         r_row_meta;
  logic [3:0]         r_row_sync;

  // Per-scan accumulator
  logic               r_acc_hit;
  logic [3:0]         r_acc_code;
  logic               r_scan_done;

  // Debounce state
  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cand, w_cand_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [3:0]         r_rel, w_rel_nxt;
  logic               w_accept;
  logic [3:0]         w_cnt_inc;
  logic [3:0]         w_rel_inc;

  logic [3:0]         r_key_code;
  logic               r_key_valid;

  // Rows are sampled at the end of each column slot, giving the keypad lines
  // and the two-flop synchroniser time to settle after the column change.
  logic               w_sample;
  logic               w_col_hit;
  logic [1:0]         w_col_row;
  logic [3:0]         w_col_code;

  assign w_sample   = (r_div == c_DIV_LAST);
  assign w_col_hit  = ~&r_row_sync;
  assign w_col_code = {w_col_row, r_col_idx};

  // Lowest pressed row within the driven column gives that column's lowest code.
  always_comb begin
    w_col_row = 2'd0;
    if (!r_row_sync[0])      w_col_row = 2'd0;
    else if (!r_row_sync[1]) w_col_row = 2'd1;
    else if (!r_row_sync[2]) w_col_row = 2'd2;
    else if (!r_row_sync[3]) w_col_row = 2'd3;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_div       <= '0;
      r_col_idx   <= 2'd0;
      r_col_drive <= 4'b1110;
      r_row_meta  <= 4'b1111;
      r_row_sync  <= 4'b1111;
      r_acc_hit   <= 1'b0;
      r_acc_code  <= 4'd0;
      r_scan_done <= 1'b0;
    end else begin
      r_row_meta  <= row_in;
      r_row_sync  <= r_row_meta;
      r_scan_done <= w_sample && (r_col_idx == 2'd3);
      if (w_sample) begin
        r_div       <= '0;
        r_col_idx   <= r_col_idx + 2'd1;
        r_col_drive <= {r_col_drive[2:0], r_col_drive[3]};
        if (r_col_idx == 2'd0) begin
          // First column of a scan discards the previous scan's result.
          r_acc_hit  <= w_col_hit;
          r_acc_code <= w_col_hit ? w_col_code : 4'd0;
        end else if (w_col_hit && (!r_acc_hit || (w_col_code < r_acc_code))) begin
          r_acc_hit  <= 1'b1;
          r_acc_code <= w_col_code;
        end
      end else begin
        r_div <= r_div + c_DIV_W'(1);
      end
    end
  end

  // Saturating increments so the counters can never wrap back below threshold.
  assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  assign w_rel_inc = (r_rel == 4'hF) ? r_rel : r_rel + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_rel_nxt   = r_rel;
    w_accept    = 1'b0;
    if (r_scan_done) begin
      case (r_state)
        ST_IDLE: begin
          if (r_acc_hit) begin
            w_state_nxt = ST_CAND;
            w_cand_nxt  = r_acc_code;
            w_cnt_nxt   = 4'd1;
          end
        end
        ST_CAND: begin
          if (!r_acc_hit) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
          end else if (r_acc_code == r_cand) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= c_DEB) begin
              w_state_nxt = ST_HELD;
              w_cnt_nxt   = 4'd0;
              w_rel_nxt   = 4'd0;
              w_accept    = 1'b1;
            end
          end else begin
            w_cand_nxt = r_acc_code;
            w_cnt_nxt  = 4'd1;
          end
        end
        ST_HELD: begin
          // Any key, even a different one, keeps the held state alive.
          if (r_acc_hit) begin
            w_rel_nxt = 4'd0;
          end else begin
            w_rel_nxt = w_rel_inc;
            if (w_rel_inc >= c_DEB) begin
              w_state_nxt = ST_IDLE;
              w_rel_nxt   = 4'd0;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
          w_rel_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_cand      <= 4'd0;
      r_cnt       <= 4'd0;
      r_rel       <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rel       <= w_rel_nxt;
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= r_cand;
    end
  end

  assign col_drive = r_col_drive;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = (r_state == ST_HELD);

`ifdef PARK_KEYMAP_EN
  logic       r_entry_req;
  logic       r_exit_req;
  logic [1:0] r_exit_slot;

  // Requests share the key_valid cycle; code 7 exits using the slot already
  // latched, which a code-7 press never changes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_entry_req <= 1'b0;
      r_exit_req  <= 1'b0;
      r_exit_slot <= 2'd0;
    end else begin
      r_entry_req <= w_accept && (r_cand == 4'd3);
      r_exit_req  <= w_accept && (r_cand == 4'd7);
      if (w_accept) begin
        case (r_cand)
          4'd0:    r_exit_slot <= 2'd0;
          4'd1:    r_exit_slot <= 2'd1;
          4'd2:    r_exit_slot <= 2'd2;
          4'd4:    r_exit_slot <= 2'd3;
          default: r_exit_slot <= r_exit_slot;
        endcase
      end
    end
  end

  assign entry_req = r_entry_req;
  assign exit_req  = r_exit_req;
  assign exit_slot = r_exit_slot;
`else
  assign entry_req = 1'b0;
  assign exit_req  = 1'b0;
  assign exit_slot = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Scoreboard bench for keypad_scanner. A keypad model turns a
//            16-bit pressed-key mask into row levels; a scan-level reference
//            model predicts accepted presses into a queue that a monitor
//            drains on every key_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_slot;

  logic [15:0] mask = 16'h0000;

  always #5 CLK = ~CLK;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .row_in    (row_in),
    .col_drive (col_drive),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .entry_req (entry_req),
    .exit_req  (exit_req),
    .exit_slot (exit_slot)
  );

  // Physical keypad: a pressed key shorts its row to its column's low drive.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_drive[c])
        for (int r = 0; r < 4; r++)
          if (mask[r*4+c]) row_in[r] = 1'b0;
  end

  typedef struct packed {
    logic [3:0] code;
    logic       entry;
    logic       exit_r;
    logic [1:0] slot;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (one entry per full scan) -------------
  bit m_hits[$];
  int m_codes[$];
  bit m_held;
  int m_code_out;
  int m_slot;

  function automatic int lowest_key(input logic [15:0] mk);
    for (int i = 0; i < 16; i++) if (mk[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_hits.delete();
    m_codes.delete();
    exp_q.delete();
    m_held     = 1'b0;
    m_code_out = 0;
    m_slot     = 0;
  endtask

  // A press is accepted when the last DEB scans all saw the same lowest key
  // and nothing is held; a hold ends after DEB consecutive empty scans.
  task automatic model_scan(input logic [15:0] mk);
    int  n;
    bit  all_hit, all_none, all_same;
    exp_t e;
    m_hits.push_back(mk != 16'h0);
    m_codes.push_back(lowest_key(mk));
    n = m_hits.size();
    if (n < DEB) return;
    all_hit = 1; all_none = 1; all_same = 1;
    for (int k = n - DEB; k < n; k++) begin
      if (!m_hits[k]) all_hit = 0;
      if (m_hits[k])  all_none = 0;
      if (m_codes[k] != m_codes[n-1]) all_same = 0;
    end
    if (!m_held) begin
      if (all_hit && all_same) begin
        m_held     = 1'b1;
        m_code_out = m_codes[n-1];
        e.code   = 4'(m_code_out);
        e.entry  = 1'b0;
        e.exit_r = 1'b0;
`ifdef PARK_KEYMAP_EN
        if (m_code_out == 0 || m_code_out == 1 || m_code_out == 2) m_slot = m_code_out;
        if (m_code_out == 4) m_slot = 3;
        e.entry  = (m_code_out == 3);
        e.exit_r = (m_code_out == 7);
`endif
        e.slot = 2'(m_slot);
        exp_q.push_back(e);
      end
    end else if (all_none) begin
      m_held = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------------------------------------
  logic prev_valid = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (key_valid) begin
      if (prev_valid) begin
        vectors++; miscompares++;
        $display("FAIL valid_twice: key_valid high on two consecutive cycles at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_valid: got pulse with code %0d, expected none at %0t", key_code, $time);
      end else begin
        e = exp_q.pop_front();
        check("valid_code",  key_code,  e.code);
        check("entry_req",   entry_req, e.entry);
        check("exit_req",    exit_req,  e.exit_r);
        check("valid_slot",  exit_slot, e.slot);
      end
    end else if (entry_req || exit_req) begin
      vectors++; miscompares++;
      $display("FAIL stray_req: got entry=%0d exit=%0d, expected 0 without key_valid", entry_req, exit_req);
    end
    prev_valid <= key_valid;
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic do_reset();
    @(negedge CLK);
    RST  = 1'b0;
    mask = 16'h0;
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // One full scan with a constant mask; checks outputs produced by the
  // previous scan's decision, which land on this scan's first edge.
  task automatic run_scan(input logic [15:0] mk);
    #1 mask = mk;
    @(posedge CLK);
    #1;
    check("key_held",  key_held,  m_held);
    check("key_code",  key_code,  m_code_out);
    check("exit_slot", exit_slot, m_slot);
    repeat (SCAN_CYC - 1) @(posedge CLK);
    model_scan(mk);
  endtask

  task automatic run_n(input logic [15:0] mk, input int n);
    for (int i = 0; i < n; i++) run_scan(mk);
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_col_drive", col_drive, 4'hE);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code",  key_code,  0);
    check("rst_key_held",  key_held,  0);
    check("rst_slot",      exit_slot, 0);

    // Accept key 6, then reset in the middle of the next scan.
    run_n(16'h0040, 3);
    #1 mask = 16'h0040;
    repeat (9) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("mid_rst_col_drive", col_drive, 4'hE);
    check("mid_rst_key_valid", key_valid, 0);
    check("mid_rst_key_held",  key_held,  0);
    check("mid_rst_key_code",  key_code,  0);
    mask = 16'h0;
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check("restart_col0", col_drive, 4'hE);
    @(posedge CLK);
    #1 check("restart_col1", col_drive, 4'hD);

    do_reset();
    // Stable press row1,col2 (code 6) for 5 scans, release for 2.
    run_n(16'h0040, 5);
    run_n(16'h0000, 2);
    run_scan(16'h0000);
    // Bounce: press, release, press, then release.
    run_scan(16'h0040);
    run_scan(16'h0000);
    run_scan(16'h0040);
    run_n(16'h0000, 3);
    // Two keys together: lowest code 5 wins.
    run_n(16'h0220, 3);
    run_n(16'h0000, 3);
    // Held 5, add 9, release all, then 9 alone.
    run_n(16'h0020, 3);
    run_n(16'h0220, 2);
    run_n(16'h0000, 2);
    run_n(16'h0200, 3);
    run_n(16'h0000, 2);
    // Keymap: slot key 2, exit key 7, entry key 3.
    run_n(16'h0004, 2);
    run_n(16'h0000, 2);
    run_n(16'h0080, 2);
    run_n(16'h0000, 2);
    run_n(16'h0008, 2);
    run_n(16'h0000, 2);
    run_n(16'h0010, 2);
    run_n(16'h0000, 2);

    // Randomised scan-aligned patterns.
    for (int it = 0; it < 40; it++) begin
      logic [15:0] mk;
      int kind;
      kind = $urandom_range(0, 3);
      mk = 16'h0;
      case (kind)
        0: mk = 16'h0;
        1: mk[$urandom_range(0, 15)] = 1'b1;
        2: begin
          mk[$urandom_range(0, 15)] = 1'b1;
          mk[$urandom_range(0, 15)] = 1'b1;
        end
        default: mk[$urandom_range(0, 7)] = 1'b1;
      endcase
      run_n(mk, $urandom_range(1, 4));
    end
    run_n(16'h0000, 3);

    repeat (SCAN_CYC) @(posedge CLK);
    #1 check("pending_expected", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
